// File: rtl/key_pio_pkg.sv
// key_pio_pkg: register map, edge-type encodings and the edge-select helper shared by key_pio and its bench.
// Ports: none (package).
// Build option: KEY_PIO_DEBOUNCE_EN. DEBOUNCE_EN mirrors it so other code can see which build it is in.
package key_pio_pkg;

  // Avalon-MM register map. The 2-bit address matches the output PIO.
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  // Which transitions of the debounced value set edge_capture.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif

  // Picks the edge set that feeds edge_capture. The vectors are padded to the full 8-bit bus width.
  function automatic logic [7:0] edge_select(input logic [7:0] rise,
                                             input logic [7:0] fall,
                                             input int         edge_type);
    logic [7:0] sel;
    sel = rise | fall;
    if (edge_type == EDGE_RISE) sel = rise;
    if (edge_type == EDGE_FALL) sel = fall;
    return sel;
  endfunction

endpackage

// File: rtl/key_pio_debounce.sv
// key_pio_debounce: synchronizes one asynchronous input bit, then debounces it.
// Ports: clk, reset_n (async, active-low), din (async input bit), stable (debounced, synchronous output).
// Build option: KEY_PIO_DEBOUNCE_EN. When it is defined, a new level must hold for DEBOUNCE_CYCLES clocks.
//   When it is undefined, stable follows the synchronizer output with one clock of delay.
module key_pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  logic sync1;
  logic sync2;

  // Two-flop synchronizer. Its reset value is the idle level, so releasing reset causes no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_BIT;
      sync2 <= RESET_BIT;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive clocks on which sync2 differs from stable.
  // The change is accepted on the clock where the count is already CNT_LAST, which is the
  // DEBOUNCE_CYCLES-th differing clock. Any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= RESET_BIT;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable <= RESET_BIT;
    else          stable <= sync2;
  end
`endif

endmodule

// File: rtl/key_pio.sv
// key_pio: Avalon-MM input PIO. It synchronizes and debounces board inputs, captures edges
//   into a sticky register and drives a maskable level irq.
// Ports: clk, reset_n (async, active-low); address, chipselect, write_n, writedata are the slave
//   write side; readdata is combinational with zero wait states; in_port carries the async inputs;
//   irq is an active-high level.
// Build option: KEY_PIO_DEBOUNCE_EN. It enables the per-bit debounce counters in key_pio_debounce.
module key_pio
  import key_pio_pkg::*;
#(
  parameter int         DATA_W          = 8,
  parameter int         EDGE_TYPE       = 1,
  parameter logic [7:0] RESET_VAL       = 8'hFF,
  parameter int         DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [7:0]        writedata,
  input  logic [DATA_W-1:0] in_port,
  output logic [7:0]        readdata,
  output logic              irq
);

  logic [DATA_W-1:0] stable;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] edge_capture;
  logic [DATA_W-1:0] irq_mask;
  logic [DATA_W-1:0] edge_set;
  logic [DATA_W-1:0] cap_clr;
  logic [7:0]        edge_sel;
  logic              wr_en;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    key_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VAL[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .stable  (stable[i])
    );
  end

  assign wr_en = chipselect && !write_n;

  // Edges are taken from the debounced value against its one-clock-old copy.
  assign edge_sel = edge_select(8'(stable & ~prev), 8'(~stable & prev), EDGE_TYPE);
  assign edge_set = edge_sel[DATA_W-1:0];

  assign cap_clr = (wr_en && address == ADDR_EDGE_CAP) ? writedata[DATA_W-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= RESET_VAL[DATA_W-1:0];
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      prev <= stable;
      // Clear is applied before set. A new edge on a bit being cleared in the same clock keeps the bit at 1.
      edge_capture <= (edge_capture & ~cap_clr) | edge_set;
      if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[DATA_W-1:0];
    end
  end

  // Reads have no side effects, so readdata does not need to be qualified by chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[DATA_W-1:0] = stable;
      ADDR_IRQ_MASK: readdata[DATA_W-1:0] = irq_mask;
      ADDR_EDGE_CAP: readdata[DATA_W-1:0] = edge_capture;
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_key_pio.sv
module tb_key_pio;
  import key_pio_pkg::*;

  // Clocks from an in_port change to DATA (debounced or plain build). Capture follows one clock later.
  localparam int LAT = DEBOUNCE_EN ? 6 : 3;

  logic       clk;
  logic       reset_n;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] in_port;
  logic [7:0] readdata;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [1:0] addr;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  key_pio #(
    .DATA_W          (8),
    .EDGE_TYPE       (1),
    .RESET_VAL       (8'hFF),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input string tag, input logic [1:0] a, input logic [7:0] v);
    exp_t e;
    e.tag  = tag;
    e.addr = a;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Pops each queued expectation and reads back its register. The reads are spaced 1 time unit apart, after a negedge.
  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      address = e.addr;
      #1;
      checks++;
      assert (readdata === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, readdata, e.val);
      end
    end
  endtask

  task automatic check_irq(input string tag, input logic exp);
    checks++;
    assert (irq === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, irq, exp);
    end
  endtask

  // The strobe is asserted for exactly one rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 8'h00;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_port    = 8'hFF;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = ADDR_DATA;
    writedata  = 8'h00;
    tick(3);
    reset_n = 1'b1;

    // Reset state.
    push_exp("rst_data", ADDR_DATA, 8'hFF);
    push_exp("rst_rsvd", ADDR_RSVD, 8'h00);
    push_exp("rst_mask", ADDR_IRQ_MASK, 8'h00);
    push_exp("rst_cap", ADDR_EDGE_CAP, 8'h00);
    drain();
    check_irq("rst_irq", 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_irq("idle_irq", 1'b0);
    end
    push_exp("idle_data", ADDR_DATA, 8'hFF);
    push_exp("idle_cap", ADDR_EDGE_CAP, 8'h00);
    drain();

    // in_port[0] falls and is held low. DATA changes after exactly LAT clocks, not before.
    in_port = 8'hFE;
    tick(LAT - 1);
    push_exp("lat_early_data", ADDR_DATA, 8'hFF);
    drain();
    tick(1);
    push_exp("lat_data", ADDR_DATA, 8'hFE);
    push_exp("lat_cap_early", ADDR_EDGE_CAP, 8'h00);
    drain();
    tick(1);
    push_exp("fall_cap", ADDR_EDGE_CAP, 8'h01);
    drain();
    check_irq("fall_irq_masked", 1'b0);

    // Unmask bit 0 so irq rises. Then write 1 to clear the capture bit, which drops irq.
    bus_write(ADDR_IRQ_MASK, 8'h01);
    check_irq("mask_irq_on", 1'b1);
    push_exp("mask_rd", ADDR_IRQ_MASK, 8'h01);
    drain();
    bus_write(ADDR_EDGE_CAP, 8'h01);
    check_irq("clr_irq_off", 1'b0);
    push_exp("clr_cap", ADDR_EDGE_CAP, 8'h00);
    drain();

    // The reserved register ignores writes.
    bus_write(ADDR_RSVD, 8'hA5);
    push_exp("rsvd_rd", ADDR_RSVD, 8'h00);
    push_exp("rsvd_mask", ADDR_IRQ_MASK, 8'h01);
    drain();

    // A 3-clock low pulse on bit 1 is shorter than the debounce window. The plain build passes it through.
    in_port = 8'hFC;
    tick(3);
    push_exp("glitch_mid_data", ADDR_DATA, DEBOUNCE_EN ? 8'hFE : 8'hFC);
    drain();
    in_port = 8'hFE;
    tick(10);
    push_exp("glitch_data", ADDR_DATA, 8'hFE);
    push_exp("glitch_cap", ADDR_EDGE_CAP, DEBOUNCE_EN ? 8'h00 : 8'h02);
    drain();
    check_irq("glitch_irq", 1'b0);
    bus_write(ADDR_EDGE_CAP, 8'h02);

    // A clear of bit 2 lands on the same clock as its falling edge, and the set wins.
    in_port = 8'hFA;
    tick(LAT);
    bus_write(ADDR_EDGE_CAP, 8'h04);
    push_exp("collide_cap", ADDR_EDGE_CAP, 8'h04);
    push_exp("collide_data", ADDR_DATA, 8'hFA);
    drain();
    check_irq("collide_irq", 1'b0);
    bus_write(ADDR_EDGE_CAP, 8'h04);
    push_exp("collide_clr", ADDR_EDGE_CAP, 8'h00);
    drain();

    // With falling-edge capture selected, rising edges set nothing.
    in_port = 8'hFF;
    tick(LAT + 2);
    push_exp("rise_data", ADDR_DATA, 8'hFF);
    push_exp("rise_cap", ADDR_EDGE_CAP, 8'h00);
    drain();

    // Clearing the mask drops irq while the capture bit stays set.
    in_port = 8'hFE;
    tick(LAT + 1);
    check_irq("remask_irq_on", 1'b1);
    bus_write(ADDR_IRQ_MASK, 8'h00);
    check_irq("unmask_irq_off", 1'b0);
    push_exp("sticky_cap", ADDR_EDGE_CAP, 8'h01);
    drain();
    bus_write(ADDR_EDGE_CAP, 8'h01);
    bus_write(ADDR_IRQ_MASK, 8'h0F);
    in_port = 8'hFF;
    tick(LAT + 2);
    push_exp("pre_rst_mask", ADDR_IRQ_MASK, 8'h0F);
    push_exp("pre_rst_cap", ADDR_EDGE_CAP, 8'h00);
    drain();

    // Reset arrives partway through bit 3's debounce, and in_port is restored before release.
    in_port = 8'hF7;
    tick(2);
    reset_n = 1'b0;
    in_port = 8'hFF;
    tick(2);
    push_exp("in_rst_data", ADDR_DATA, 8'hFF);
    push_exp("in_rst_mask", ADDR_IRQ_MASK, 8'h00);
    push_exp("in_rst_cap", ADDR_EDGE_CAP, 8'h00);
    drain();
    check_irq("in_rst_irq", 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_irq("post_rst_irq", 1'b0);
    end
    push_exp("post_rst_data", ADDR_DATA, 8'hFF);
    push_exp("post_rst_cap", ADDR_EDGE_CAP, 8'h00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
